// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the loader (0) and the pixel controller (1).
// One access at a time: grant, hold enables for ACCESS_CYCLES, then a turnaround cycle with done.
module sram_arbiter #(
    parameter int unsigned ADDR_BITS     = 16,
    parameter int unsigned DATA_BITS     = 24,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic                 wr_0,
    input  logic                 wr_1,
    input  logic [ADDR_BITS-1:0] addr_0,
    input  logic [ADDR_BITS-1:0] addr_1,
    input  logic [DATA_BITS-1:0] wdata_0,
    input  logic [DATA_BITS-1:0] wdata_1,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic                 done_0,
    output logic                 done_1,
    output logic [DATA_BITS-1:0] rdata_0,
    output logic [DATA_BITS-1:0] rdata_1,
    output logic                 busy,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_BITS-1:0] sram_w_data,
    input  logic [DATA_BITS-1:0] sram_r_data
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StTurn   = 2'd2;
    localparam logic [3:0] CntLoad  = 4'(ACCESS_CYCLES - 1);

    logic [1:0]           state_q;
    logic                 last_owner_q;
    logic                 owner_q;
    logic                 wr_q;
    logic [3:0]           cnt_q;

    logic                 pick;
    logic                 sel_wr;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    always_comb begin
        pick      = (req_0 && req_1) ? ~last_owner_q : req_1;
        sel_wr    = pick ? wr_1 : wr_0;
        sel_addr  = pick ? addr_1 : addr_0;
        sel_wdata = pick ? wdata_1 : wdata_0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            last_owner_q      <= 1'b1;
            owner_q           <= 1'b0;
            wr_q              <= 1'b0;
            cnt_q             <= 4'd0;
            gnt_0             <= 1'b0;
            gnt_1             <= 1'b0;
            done_0            <= 1'b0;
            done_1            <= 1'b0;
            rdata_0           <= '0;
            rdata_1           <= '0;
            busy              <= 1'b0;
            sram_read_enable  <= 1'b0;
            sram_write_enable <= 1'b0;
            sram_address      <= '0;
            sram_w_data       <= '0;
        end else begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_0 || req_1) begin
                        state_q           <= StAccess;
                        owner_q           <= pick;
                        wr_q              <= sel_wr;
                        cnt_q             <= CntLoad;
                        gnt_0             <= ~pick;
                        gnt_1             <= pick;
                        busy              <= 1'b1;
                        sram_write_enable <= sel_wr;
                        sram_read_enable  <= ~sel_wr;
                        sram_address      <= sel_addr;
                        sram_w_data       <= sel_wr ? sel_wdata : '0;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q           <= StTurn;
                        gnt_0             <= 1'b0;
                        gnt_1             <= 1'b0;
                        sram_read_enable  <= 1'b0;
                        sram_write_enable <= 1'b0;
                        sram_w_data       <= '0;
                        last_owner_q      <= owner_q;
                        done_0            <= ~owner_q;
                        done_1            <= owner_q;
                        if (!wr_q) begin
                            if (owner_q) rdata_1 <= sram_r_data;
                            else         rdata_0 <= sram_r_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: one instance with ACCESS_CYCLES=2, one with ACCESS_CYCLES=1.
module tb_sram_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 24;

    typedef struct {
        logic          owner;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Instance A, ACCESS_CYCLES = 2
    logic          req_0, req_1, wr_0, wr_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, done_0, done_1, busy, re, we;
    logic [DW-1:0] rdata_0, rdata_1, s_wdata, s_rdata;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] mem0 [0:65535];

    // Instance B, ACCESS_CYCLES = 1
    logic          b_req_0, b_req_1, b_wr_0, b_wr_1, b_preload;
    logic [AW-1:0] b_addr_0, b_addr_1;
    logic [DW-1:0] b_wdata_0, b_wdata_1;
    logic          b_gnt_0, b_gnt_1, b_done_0, b_done_1, b_busy, b_re, b_we;
    logic [DW-1:0] b_rdata_0, b_rdata_1, b_s_wdata, b_s_rdata;
    logic [AW-1:0] b_s_addr;
    logic [DW-1:0] mem1 [0:65535];

    always @(posedge clk) if (we) mem0[s_addr] <= s_wdata;
    assign s_rdata = re ? mem0[s_addr] : '0;

    always @(posedge clk) begin
        if (b_preload)  mem1[16'hFFFF] <= 24'h5A5A5A;
        else if (b_we)  mem1[b_s_addr] <= b_s_wdata;
    end
    assign b_s_rdata = b_re ? mem1[b_s_addr] : '0;

    sram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .ACCESS_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .wr_0(wr_0), .wr_1(wr_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1), .busy(busy),
        .sram_read_enable(re), .sram_write_enable(we), .sram_address(s_addr),
        .sram_w_data(s_wdata), .sram_r_data(s_rdata)
    );

    sram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .ACCESS_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_0(b_req_0), .req_1(b_req_1), .wr_0(b_wr_0), .wr_1(b_wr_1),
        .addr_0(b_addr_0), .addr_1(b_addr_1), .wdata_0(b_wdata_0), .wdata_1(b_wdata_1),
        .gnt_0(b_gnt_0), .gnt_1(b_gnt_1), .done_0(b_done_0), .done_1(b_done_1),
        .rdata_0(b_rdata_0), .rdata_1(b_rdata_1), .busy(b_busy),
        .sram_read_enable(b_re), .sram_write_enable(b_we), .sram_address(b_s_addr),
        .sram_w_data(b_s_wdata), .sram_r_data(b_s_rdata)
    );

    // Advance one cycle and sample 1ns after the edge; enable exclusivity is checked every cycle.
    task automatic tick;
        @(posedge clk);
        #1;
        checks++;
        if ((re && we) || (b_re && b_we) || ((re || we) && !(gnt_0 || gnt_1)) ||
            ((b_re || b_we) && !(b_gnt_0 || b_gnt_1))) begin
            errors++;
            $display("FAIL enable_exclusive: A re=%b we=%b gnt=%b%b B re=%b we=%b gnt=%b%b, required one enable only while granted",
                     re, we, gnt_1, gnt_0, b_re, b_we, b_gnt_1, b_gnt_0);
        end
    endtask

    // Single access on instance A with full latency and window checks.
    task automatic access_a(input logic who, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        exp_t          e;
        int            c;
        logic [DW-1:0] other_rd, got_rd;
        other_rd = who ? rdata_0 : rdata_1;
        if (who) begin req_1 = 1; wr_1 = wr; addr_1 = a; wdata_1 = wd; end
        else     begin req_0 = 1; wr_0 = wr; addr_0 = a; wdata_0 = wd; end
        sb.push_back('{who, exp_rd});
        c = 0;
        while (1) begin
            tick();
            c++;
            if (c <= 2) begin
                checks++;
                if ({gnt_1, gnt_0} !== (who ? 2'b10 : 2'b01) || we !== wr || re !== !wr ||
                    s_addr !== a || s_wdata !== (wr ? wd : '0)) begin
                    errors++;
                    $display("FAIL access_window c=%0d: gnt=%b%b we=%b re=%b addr=%h wdata=%h, required owner=%0d wr=%b addr=%h wdata=%h",
                             c, gnt_1, gnt_0, we, re, s_addr, s_wdata, who, wr, a, wr ? wd : '0);
                end
                // Latched values must survive input changes during ACCESS.
                if (who) begin addr_1 = ~a; wdata_1 = ~wd; wr_1 = ~wr; end
                else     begin addr_0 = ~a; wdata_0 = ~wd; wr_0 = ~wr; end
            end
            if (done_0 || done_1 || c >= 10) break;
        end
        checks++;
        if (c != 3 || done_0 !== !who || done_1 !== who) begin
            errors++;
            $display("FAIL done_timing: done=%b%b at cycle %0d, required done_%0d at cycle 3",
                     done_1, done_0, c, who);
        end
        e = sb.pop_front();
        got_rd = e.owner ? rdata_1 : rdata_0;
        checks++;
        if (got_rd !== e.rdata) begin
            errors++;
            $display("FAIL rdata_owner: got %h, required %h", got_rd, e.rdata);
        end
        checks++;
        if ((who ? rdata_0 : rdata_1) !== other_rd) begin
            errors++;
            $display("FAIL rdata_other: got %h, required %h", who ? rdata_0 : rdata_1, other_rd);
        end
        if (who) req_1 = 0; else req_0 = 0;
        tick();
        checks++;
        if (done_0 || done_1 || busy || gnt_0 || gnt_1) begin
            errors++;
            $display("FAIL after_turn: done=%b%b busy=%b gnt=%b%b, required all 0",
                     done_1, done_0, busy, gnt_1, gnt_0);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) tick();
        checks++;
        if ({gnt_0, gnt_1, done_0, done_1, busy, re, we} !== 7'b0 || s_addr !== '0 ||
            s_wdata !== '0 || rdata_0 !== '0 || rdata_1 !== '0) begin
            errors++;
            $display("FAIL reset_a: ctl=%b addr=%h wdata=%h rdata=%h/%h, required all 0",
                     {gnt_0, gnt_1, done_0, done_1, busy, re, we}, s_addr, s_wdata, rdata_0, rdata_1);
        end
        checks++;
        if ({b_gnt_0, b_gnt_1, b_done_0, b_done_1, b_busy, b_re, b_we} !== 7'b0 ||
            b_s_addr !== '0 || b_rdata_0 !== '0 || b_rdata_1 !== '0) begin
            errors++;
            $display("FAIL reset_b: ctl=%b addr=%h, required all 0",
                     {b_gnt_0, b_gnt_1, b_done_0, b_done_1, b_busy, b_re, b_we}, b_s_addr);
        end
        rst = 0;
        tick();
        checks++;
        if (busy || gnt_0 || gnt_1) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b gnt=%b%b, required 0", busy, gnt_1, gnt_0);
        end
    endtask

    task automatic test_single_write_read;
        access_a(1'b0, 1'b1, 16'h0005, 24'hA1B2C3, 24'h000000);
        checks++;
        if (mem0[16'h0005] !== 24'hA1B2C3) begin
            errors++;
            $display("FAIL sram_dump: mem[0005]=%h, required a1b2c3", mem0[16'h0005]);
        end
        access_a(1'b1, 1'b0, 16'h0005, 24'h000000, 24'hA1B2C3);
    endtask

    task automatic test_tie;
        exp_t       e;
        logic [7:0] en_pat, g0_pat, g1_pat;
        en_pat = '0; g0_pat = '0; g1_pat = '0;
        req_0 = 1; wr_0 = 1; addr_0 = 16'h0010; wdata_0 = 24'h111111;
        req_1 = 1; wr_1 = 1; addr_1 = 16'h0020; wdata_1 = 24'h222222;
        sb.push_back('{1'b0, rdata_0});
        sb.push_back('{1'b1, rdata_1});
        for (int c = 1; c <= 8; c++) begin
            tick();
            en_pat = {en_pat[6:0], re | we};
            g0_pat = {g0_pat[6:0], gnt_0};
            g1_pat = {g1_pat[6:0], gnt_1};
            if (done_0 || done_1) begin
                e = sb.pop_front();
                checks++;
                if (done_1 !== e.owner || (done_0 && done_1) ||
                    (e.owner ? rdata_1 : rdata_0) !== e.rdata) begin
                    errors++;
                    $display("FAIL tie_order: done=%b%b rdata=%h, required owner %0d rdata %h",
                             done_1, done_0, e.owner ? rdata_1 : rdata_0, e.owner, e.rdata);
                end
                if (done_0) req_0 = 0;
                if (done_1) req_1 = 0;
            end
        end
        checks++;
        if (en_pat !== 8'b11001100 || g0_pat !== 8'b11000000 || g1_pat !== 8'b00001100) begin
            errors++;
            $display("FAIL tie_windows: en=%b g0=%b g1=%b, required 11001100 11000000 00001100",
                     en_pat, g0_pat, g1_pat);
        end
        checks++;
        if (sb.size() != 0 || mem0[16'h0010] !== 24'h111111 || mem0[16'h0020] !== 24'h222222) begin
            errors++;
            $display("FAIL tie_complete: pending=%0d mem10=%h mem20=%h, required 0 111111 222222",
                     sb.size(), mem0[16'h0010], mem0[16'h0020]);
        end
        sb.delete();
        req_0 = 0; req_1 = 0;
        tick();
    endtask

    task automatic test_fairness;
        exp_t e;
        int   n, last;
        req_0 = 1; wr_0 = 0; addr_0 = 16'h0010;
        req_1 = 1; wr_1 = 0; addr_1 = 16'h0020;
        for (int i = 0; i < 8; i++)
            sb.push_back('{i[0], i[0] ? 24'h222222 : 24'h111111});
        n = 0;
        last = 0;
        for (int c = 1; c <= 60 && n < 8; c++) begin
            tick();
            if (done_0 || done_1) begin
                e = sb.pop_front();
                checks++;
                if (done_1 !== e.owner || (done_0 && done_1) ||
                    (e.owner ? rdata_1 : rdata_0) !== e.rdata || c - last != (n == 0 ? 3 : 4)) begin
                    errors++;
                    $display("FAIL fairness #%0d: done=%b%b rdata=%h gap=%0d, required owner %0d rdata %h gap %0d",
                             n, done_1, done_0, e.owner ? rdata_1 : rdata_0, c - last, e.owner,
                             e.rdata, n == 0 ? 3 : 4);
                end
                last = c;
                n++;
            end
        end
        req_0 = 0; req_1 = 0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL fairness_timeout: %0d accesses, required 8", n);
        end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_mid_access;
        int n0, n1, first;
        access_a(1'b0, 1'b0, 16'h0010, 24'h000000, 24'h111111);
        req_1 = 1; wr_1 = 0; addr_1 = 16'h0020;
        tick();
        checks++;
        if (gnt_1 !== 1'b1 || re !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: gnt_1=%b re=%b, required 1 1", gnt_1, re);
        end
        rst = 1;
        req_1 = 0;
        tick();
        checks++;
        if ({gnt_0, gnt_1, done_0, done_1, busy, re, we} !== 7'b0 || s_addr !== '0 ||
            s_wdata !== '0 || rdata_0 !== '0 || rdata_1 !== '0) begin
            errors++;
            $display("FAIL mid_reset: ctl=%b addr=%h wdata=%h rdata=%h/%h, required all 0",
                     {gnt_0, gnt_1, done_0, done_1, busy, re, we}, s_addr, s_wdata, rdata_0, rdata_1);
        end
        rst = 0;
        n0 = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done_0 || done_1 || busy) n0++;
        end
        checks++;
        if (n0 != 0) begin
            errors++;
            $display("FAIL aborted_done: %0d active cycles after reset, required 0", n0);
        end
        // last_owner must be back at 1, so requester 0 wins this tie.
        req_0 = 1; wr_0 = 0; addr_0 = 16'h0010;
        req_1 = 1; wr_1 = 0; addr_1 = 16'h0020;
        tick();
        checks++;
        if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tie: gnt=%b%b, required 01", gnt_1, gnt_0);
        end
        n0 = 0; n1 = 0; first = -1;
        for (int c = 0; c < 20 && (n0 + n1) < 2; c++) begin
            tick();
            if (done_0) begin n0++; req_0 = 0; if (first < 0) first = 0; end
            if (done_1) begin n1++; req_1 = 0; if (first < 0) first = 1; end
        end
        checks++;
        if (n0 != 1 || n1 != 1 || first != 0 || rdata_0 !== 24'h111111 || rdata_1 !== 24'h222222) begin
            errors++;
            $display("FAIL post_reset_serve: n0=%0d n1=%0d first=%0d rdata=%h/%h, required 1 1 0 111111/222222",
                     n0, n1, first, rdata_0, rdata_1);
        end
        req_0 = 0; req_1 = 0;
        tick();
    endtask

    task automatic test_single_cycle_boundary;
        exp_t e;
        b_preload = 1;
        tick();
        b_preload = 0;
        b_req_0 = 1; b_wr_0 = 0; b_addr_0 = 16'hFFFF;
        sb.push_back('{1'b0, 24'h5A5A5A});
        tick();
        b_addr_0 = 16'h1234;
        checks++;
        if (b_gnt_0 !== 1'b1 || b_re !== 1'b1 || b_we !== 1'b0 || b_s_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL b_access: gnt_0=%b re=%b we=%b addr=%h, required 1 1 0 ffff",
                     b_gnt_0, b_re, b_we, b_s_addr);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (b_done_0 !== 1'b1 || b_rdata_0 !== e.rdata || b_re !== 1'b0 || b_gnt_0 !== 1'b0) begin
            errors++;
            $display("FAIL b_done: done_0=%b rdata_0=%h re=%b gnt_0=%b, required 1 %h 0 0",
                     b_done_0, b_rdata_0, b_re, b_gnt_0, e.rdata);
        end
        b_req_0 = 0;
        tick();
        checks++;
        if (b_done_0 !== 1'b0 || b_busy !== 1'b0 || b_rdata_0 !== 24'h5A5A5A || b_rdata_1 !== '0) begin
            errors++;
            $display("FAIL b_after: done_0=%b busy=%b rdata=%h/%h, required 0 0 5a5a5a/000000",
                     b_done_0, b_busy, b_rdata_0, b_rdata_1);
        end
    endtask

    initial begin
        req_0 = 0; req_1 = 0; wr_0 = 0; wr_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        b_req_0 = 0; b_req_1 = 0; b_wr_0 = 0; b_wr_1 = 0; b_preload = 0;
        b_addr_0 = '0; b_addr_1 = '0; b_wdata_0 = '0; b_wdata_1 = '0;
        test_reset();
        test_single_write_read();
        test_tie();
        test_fairness();
        test_reset_mid_access();
        test_single_cycle_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares the single off-chip SRAM port (24-bit words, 16-bit address) between the SRAM loader/interface path and the pixel controller. It replaces the testbench-level static select with a cycle-accurate, round-robin, one-access-at-a-time scheduler. Each access holds the SRAM enables for a fixed number of cycles, captures read data, and returns a one-cycle done pulse to the owning requester.

## Interface
Parameters:
- ADDR_BITS, 16, SRAM address width
- DATA_BITS, 24, SRAM word width (3 bytes, one RGB pixel)
- ACCESS_CYCLES, 2, cycles enables are held per access; legal range 1..15

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_0 / req_1  in  1  access request from requester 0 (loader) / 1 (pixel controller)
- wr_0 / wr_1  in  1  1 = write, 0 = read; sampled at grant
- addr_0 / addr_1  in  ADDR_BITS  access address; sampled at grant
- wdata_0 / wdata_1  in  DATA_BITS  write data; sampled at grant
- gnt_0 / gnt_1  out  1  high while that requester owns the SRAM (ACCESS state)
- done_0 / done_1  out  1  one-cycle completion pulse
- rdata_0 / rdata_1  out  DATA_BITS  last read word completed for that requester
- busy  out  1  high in ACCESS or TURN
- sram_read_enable  out  1  to SRAM wrapper
- sram_write_enable  out  1  to SRAM wrapper
- sram_address  out  ADDR_BITS  to SRAM wrapper
- sram_w_data  out  DATA_BITS  to SRAM bidirectional driver
- sram_r_data  in  DATA_BITS  from SRAM bidirectional bus

## Operation
- States: IDLE, ACCESS, TURN. All outputs registered.
- IDLE: if neither req is high, stay. If exactly one is high, grant it. If both are high, grant the requester not served last (`last_owner` register).
- On grant: latch owner, wr, addr, and wdata into internal registers; load counter with ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - Assert gnt_owner.
  - Drive sram_address = latched addr.
  - For a write: sram_write_enable = 1, sram_w_data = latched wdata.
  - For a read: sram_read_enable = 1, sram_w_data = 0.
  - Decrement the counter each cycle. When it reaches 0:
    - For a read, capture sram_r_data into rdata_owner.
    - Set done_owner for the next cycle.
    - Set last_owner = owner.
    - Go to TURN.
- TURN: one mandatory bus-turnaround cycle.
  - Enables low, done_owner high, no new grant.
  - Next state is IDLE.
- Requesters hold req, wr, addr, and wdata until they see done. They must drop req on the edge ending the done cycle; a req still high in the following IDLE is a new request.
- Input changes during ACCESS have no effect; the latched values are used.
- rdata_x holds its value until the next read completion for that requester. Writes never alter rdata_x.
- Enables are never both high. No enable is high outside ACCESS.

## Timing
- Reset values:
  - state = IDLE, last_owner = 1 (so requester 0 wins the first tie).
  - All gnt, done, and enable outputs = 0; busy = 0.
  - sram_address = 0, sram_w_data = 0, rdata_0 = rdata_1 = 0.
- Latency: req seen high in IDLE cycle N →
  - gnt and enable high in cycles N+1 .. N+ACCESS_CYCLES.
  - done high in cycle N+ACCESS_CYCLES+1.
  - rdata valid from cycle N+ACCESS_CYCLES+1.
- Throughput: one access per ACCESS_CYCLES+2 cycles when requests are continuous.
- Both requesters continuously requesting are served strictly alternately.
- ACCESS_CYCLES = 1: ACCESS lasts exactly one cycle; read data is captured on that cycle's closing edge.
- Counter width is 4 bits. ACCESS_CYCLES = 0 is illegal and need not be handled.
- Reset mid-ACCESS: on the next edge, all state returns to reset values. Enables drop, no done is issued, and rdata is cleared.
- Reset dominates any simultaneous request.

## Test plan
- Single write, ACCESS_CYCLES=2: req_0 with wr_0=1, addr_0=16'h0005, wdata_0=24'hA1B2C3 in cycle 0 → sram_write_enable and gnt_0 high in cycles 1–2 with sram_address=0005 and sram_w_data=A1B2C3; done_0 high only in cycle 3; the SRAM dump shows 0005=A1B2C3.
- Single read: after the write above, req_1 read of addr 0005 → sram_read_enable high for 2 cycles; rdata_1=A1B2C3 and done_1 in the same cycle; rdata_0 unchanged.
- Tie after reset: req_0 and req_1 both rise in the same cycle → requester 0 served first, then requester 1 granted in the IDLE after TURN. The two accesses' enable windows are separated by exactly 2 enable-low cycles.
- Fairness: both requesters re-request immediately for 8 accesses → grant order 0,1,0,1,0,1,0,1; the enables are never simultaneously high.
- Reset mid-access: assert rst in the 1st ACCESS cycle of a read → next cycle all outputs are at reset values and done never pulses. After reset is released, a pending req_1 is granted before req_0 only if it is the sole requester.
- Boundary, ACCESS_CYCLES=1 with addr=16'hFFFF: a read returns the preloaded value with done in cycle 2. Changing addr_0 during ACCESS does not change sram_address.
